// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with line refill
module icache_dm #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_rstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rbusy,
    input  logic        flush,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int LB = $clog2(LINES);
    localparam int TB = 32 - LB - WB - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Storage: tags and data are plain arrays; only the valid bits are reset.
    logic [TB-1:0]    tag_arr  [LINES];
    logic [31:0]      data_arr [LINES*WORDS_PER_LINE];
    logic [LINES-1:0] valid;

    // Request latched at the start of an access; drives the whole refill.
    logic [TB-1:0] req_tag;
    logic [LB-1:0] req_idx;
    logic [WB-1:0] req_word;
    logic [WB-1:0] wc;
    logic          flush_pend;

    logic [WB-1:0] a_word;
    logic [LB-1:0] a_idx;
    logic [TB-1:0] a_tag;
    logic          hit;
    logic          start;
    logic          beat;
    logic          last_beat;
    logic          addr_unused;

    assign a_word      = cpu_addr[WB+1:2];
    assign a_idx       = cpu_addr[LB+WB+1:WB+2];
    assign a_tag       = cpu_addr[31:LB+WB+2];
    assign addr_unused = ^cpu_addr[1:0];

    // A flush in the same cycle wins over the lookup, so the access misses.
    assign hit       = valid[a_idx] && (tag_arr[a_idx] == a_tag) && !flush;
    assign start     = (state == IDLE) && cpu_rstrb;
    assign beat      = (state == REFILL) && mem_ready;
    assign last_beat = beat && (wc == WB'(WORDS_PER_LINE - 1));

    // State register; reset abandons any refill immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: miss -> refill all words -> one respond cycle -> idle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && !hit) state_nx = REFILL;
            REFILL:  if (last_beat)     state_nx = RESPOND;
            RESPOND: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state; they fall asynchronously with reset.
    always_comb begin
        mem_req   = (state == REFILL);
        cpu_rbusy = (state != IDLE);
        mem_addr  = '0;
        if (state == REFILL) begin
            mem_addr = {req_tag, req_idx, wc, 2'b00};
        end
    end

    // Control datapath: request latch, word counter, valid bits, deferred flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= '0;
            flush_pend <= 1'b0;
            cpu_rdata  <= '0;
            wc         <= '0;
            req_tag    <= '0;
            req_idx    <= '0;
            req_word   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flush_pend <= 1'b0;
                    if (flush) begin
                        valid <= '0;
                    end
                    if (cpu_rstrb) begin
                        req_tag  <= a_tag;
                        req_idx  <= a_idx;
                        req_word <= a_word;
                        wc       <= '0;
                        if (hit) begin
                            cpu_rdata <= data_arr[{a_idx, a_word}];
                        end
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (beat) begin
                        wc <= wc + 1'b1;
                    end
                    if (last_beat) begin
                        valid[req_idx] <= 1'b1;
                    end
                end
                RESPOND: begin
                    cpu_rdata  <= data_arr[{req_idx, req_word}];
                    flush_pend <= 1'b0;
                    if (flush || flush_pend) begin
                        valid <= '0;
                    end
                end
                default: begin
                    flush_pend <= 1'b0;
                end
            endcase
        end
    end

    // Array writes: each returned word lands in order, tag on the final beat.
    always_ff @(posedge clk) begin
        if (beat) begin
            data_arr[{req_idx, wc}] <= mem_rdata;
        end
        if (last_beat) begin
            tag_arr[req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - scoreboard testbench for icache_dm
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_rstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_rbusy;
    logic        flush;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] addr_log[$];
    int          errors     = 0;
    int          checks     = 0;
    int          resp_count = 0;
    int          req_cycles = 0;
    int          waits      = 2;
    bit          tied       = 1'b0;

    always #5 clk = ~clk;

    icache_dm dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_rstrb (cpu_rstrb),
        .cpu_rdata (cpu_rdata),
        .cpu_rbusy (cpu_rbusy),
        .flush     (flush),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing memory: configurable wait states, or ready tied high.
    initial begin
        int cnt;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (tied) begin
                mem_ready = 1'b1;
                mem_rdata = memf(mem_addr);
                if (mem_req) begin
                    req_cycles++;
                    addr_log.push_back(mem_addr);
                end
            end else if (mem_req) begin
                req_cycles++;
                if (cnt == waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = memf(mem_addr);
                    addr_log.push_back(mem_addr);
                    cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: on each accepted fetch, wait for cpu_rbusy=0 and check data and latency.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst && cpu_rstrb) begin
                int  cnt;
                bit  done;
                exp_t e;
                cnt  = 0;
                done = 1'b0;
                while (!done) begin
                    @(negedge clk);
                    cnt++;
                    if (rst) begin
                        done = 1'b1;
                    end else if (!cpu_rbusy || cnt > 200) begin
                        if (cnt > 200) begin
                            errors++;
                            $display("FAIL resp_timeout: got busy after %0d cycles expected idle", cnt);
                        end
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_resp: got response expected none");
                        end else begin
                            e = sb.pop_front();
                            check("rdata", cpu_rdata, e.data);
                            check("latency", 32'(cnt), 32'(e.lat));
                        end
                        resp_count++;
                        done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic issue_start(input logic [31:0] a, input logic [31:0] d, input int lat,
                               input bit do_push, input bit fl);
        @(negedge clk);
        addr_log.delete();
        if (do_push) sb.push_back('{data: d, lat: lat});
        cpu_addr  = a;
        cpu_rstrb = 1'b1;
        flush     = fl;
        @(negedge clk);
        cpu_rstrb = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        int n;
        n = 0;
        while (resp_count < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (resp_count < target) begin
            errors++;
            $display("FAIL wait_resp: got %0d responses expected %0d", resp_count, target);
        end
    endtask

    task automatic wait_log(input int n_words);
        int n;
        n = 0;
        while (addr_log.size() < n_words && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (addr_log.size() < n_words) begin
            errors++;
            $display("FAIL wait_log: got %0d words expected %0d", addr_log.size(), n_words);
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d, input int lat, input bit fl);
        int target;
        target = resp_count + 1;
        issue_start(a, d, lat, 1'b1, fl);
        wait_resp(target);
    endtask

    task automatic check_addrs(input string name, input logic [31:0] base);
        check({name, "_len"}, 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            check(name, addr_log[i], base + 32'(4 * i));
        end
    endtask

    initial begin
        int snap;
        int target;
        rst       = 1'b1;
        cpu_addr  = '0;
        cpu_rstrb = 1'b0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_rbusy", 32'(cpu_rbusy), 32'h0);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_maddr", mem_addr, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Cold miss with 2 wait states: 12 refill cycles + 2.
        access(32'h0000_0000, 32'hC0DE_0000, 14, 1'b0);
        check_addrs("miss0_addr", 32'h0000_0000);

        // Hit in the same line, no backing traffic.
        snap = req_cycles;
        access(32'h0000_0004, 32'hC0DE_0004, 1, 1'b0);
        check("hit_noreq", 32'(req_cycles), 32'(snap));

        // Conflict on line 0 with tag 1, then the original line misses again.
        access(32'h0000_0100, 32'hC0DE_0100, 14, 1'b0);
        check_addrs("conf_addr", 32'h0000_0100);
        snap = req_cycles;
        access(32'h0000_0000, 32'hC0DE_0000, 14, 1'b0);
        check("remiss_req", 32'(req_cycles - snap > 0), 32'h1);

        // Flush during the second refill word: data still correct, line invalid after.
        target = resp_count + 1;
        issue_start(32'h0000_0040, 32'hC0DE_0040, 14, 1'b1, 1'b0);
        wait_log(1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_resp(target);
        snap = req_cycles;
        access(32'h0000_0040, 32'hC0DE_0040, 14, 1'b0);
        check("postflush_req", 32'(req_cycles - snap > 0), 32'h1);

        // Reset after the first ready of a refill: outputs drop without a clock edge.
        issue_start(32'h0000_0080, 32'h0, 0, 1'b0, 1'b0);
        wait_log(1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_req", 32'(mem_req), 32'h0);
        check("arst_rbusy", 32'(cpu_rbusy), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        access(32'h0000_0080, 32'hC0DE_0080, 14, 1'b0);
        check_addrs("rerefill_addr", 32'h0000_0080);

        // Ready tied high: 4 request cycles, data 6 cycles after the fetch.
        @(negedge clk);
        tied = 1'b1;
        snap = req_cycles;
        access(32'h0000_00C4, 32'hC0DE_00C4, 6, 1'b0);
        check("tied_reqcyc", 32'(req_cycles - snap), 32'd4);
        check_addrs("tied_addr", 32'h0000_00C0);

        // Flush together with a fetch of a cached line: must miss.
        snap = req_cycles;
        access(32'h0000_00C4, 32'hC0DE_00C4, 6, 1'b1);
        check("flushfetch_req", 32'(req_cycles - snap), 32'd4);

        // Hit on the refreshed line, then data holds across idle cycles.
        access(32'h0000_00C8, 32'hC0DE_00C8, 1, 1'b0);
        repeat (3) @(negedge clk);
        check("rdata_hold", cpu_rdata, 32'hC0DE_00C8);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
